// File: rtl/riscv_core_icache_nway.sv
// riscv_core_icache_nway
//   N-way set-associative, read-only instruction cache. Hits are answered
//   combinationally in the request cycle. A miss stalls the core while one
//   full line is fetched from the AXI refill master. Replacement uses the
//   lowest invalid way first, otherwise tree pseudo-LRU. A flush (FENCE.I)
//   invalidates the whole cache. Saturating hit and miss counters are kept.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_addr_from_core, i_req      fetch address and request valid
//   i_flush                      invalidate all lines (single-cycle pulse)
//   o_stall                      core must hold address and request
//   o_data_valid, o_data_to_core instruction word returned on a hit
//   o_addr_from_control_to_axi   line-aligned refill address
//   o_mem_req                    refill request, held until i_mem_done
//   i_mem_done, i_block_from_axi refill completion and line data
//   o_hit_count, o_miss_count    saturating performance counters
module riscv_core_icache_nway #(
  parameter int ADDR_WIDTH      = 64,
  parameter int CORE_DATA_WIDTH = 32,
  parameter int AXI_DATA_WIDTH  = 256,
  parameter int SETS            = 128,
  parameter int WAYS            = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ADDR_WIDTH-1:0]      i_addr_from_core,
  input  logic                       i_req,
  input  logic                       i_flush,
  output logic                       o_stall,
  output logic                       o_data_valid,
  output logic [CORE_DATA_WIDTH-1:0] o_data_to_core,
  output logic [ADDR_WIDTH-1:0]      o_addr_from_control_to_axi,
  output logic                       o_mem_req,
  input  logic                       i_mem_done,
  input  logic [AXI_DATA_WIDTH-1:0]  i_block_from_axi,
  output logic [31:0]                o_hit_count,
  output logic [31:0]                o_miss_count
);

  localparam int          OFFSET_W   = $clog2(AXI_DATA_WIDTH / 8);
  localparam int          INDEX_W    = $clog2(SETS);
  localparam int          TAG_W      = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int          WORD_SEL_W = $clog2(AXI_DATA_WIDTH / CORE_DATA_WIDTH);
  localparam int          BYTE_W     = $clog2(CORE_DATA_WIDTH / 8);
  localparam int unsigned LOG_WAYS   = $clog2(WAYS);
  localparam int          WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int          PLRU_W     = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, REFILL, FILL_WAIT} state_t;

  state_t state_q, state_d;

  logic [WAYS-1:0]           valid_q  [SETS];
  logic [PLRU_W-1:0]         plru_q   [SETS];
  logic [TAG_W-1:0]          tag_mem  [SETS][WAYS];
  logic [AXI_DATA_WIDTH-1:0] data_mem [SETS][WAYS];

  logic [WAY_W-1:0]      victim_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  flush_pend_q;
  logic [31:0]           hit_q;
  logic [31:0]           miss_q;

  logic [TAG_W-1:0]          req_tag;
  logic [INDEX_W-1:0]        req_index;
  logic [WORD_SEL_W-1:0]     req_word;
  logic [TAG_W-1:0]          fill_tag;
  logic [INDEX_W-1:0]        fill_index;
  logic                      hit;
  logic [WAY_W-1:0]          hit_way;
  logic [AXI_DATA_WIDTH-1:0] hit_line;
  logic [WAY_W-1:0]          victim;
  logic                      found_invalid;
  logic [WAYS-1:0]           set_valid;
  logic                      hit_fire;
  logic                      miss_start;
  logic                      fill_fire;

  logic unused;
  assign unused = ^i_addr_from_core[BYTE_W-1:0];

  assign req_tag    = i_addr_from_core[ADDR_WIDTH-1 -: TAG_W];
  assign req_index  = i_addr_from_core[OFFSET_W +: INDEX_W];
  assign req_word   = i_addr_from_core[OFFSET_W-1 -: WORD_SEL_W];
  assign fill_tag   = mem_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign fill_index = mem_addr_q[OFFSET_W +: INDEX_W];

  // Tree PLRU: node n has children 2n+1 / 2n+2; a node bit points toward
  // the less recently used half. Touching a way points its path away.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] cur,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] nxt;
    int unsigned       node;
    int unsigned       dir;
    nxt = cur;
    for (int unsigned l = 0; l < LOG_WAYS; l++) begin
      node = (32'd1 << l) - 32'd1 + (32'(way) >> (LOG_WAYS - l));
      dir  = (32'(way) >> (LOG_WAYS - 1 - l)) & 32'd1;
      nxt  = (nxt & ~(PLRU_W'(1) << node)) | (PLRU_W'(dir ^ 32'd1) << node);
    end
    return nxt;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] cur);
    int unsigned node;
    int unsigned v;
    int unsigned b;
    node = 0;
    v    = 0;
    for (int unsigned l = 0; l < LOG_WAYS; l++) begin
      b    = 32'((cur >> node) & PLRU_W'(1));
      v    = (v << 1) | b;
      node = 2 * node + 1 + b;
    end
    return WAY_W'(v);
  endfunction

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_line  = '0;
    set_valid = valid_q[req_index];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (set_valid[WAY_W'(w)] && tag_mem[req_index][WAY_W'(w)] == req_tag) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(w);
        hit_line = data_mem[req_index][WAY_W'(w)];
      end
    end
  end

  assign o_data_to_core = CORE_DATA_WIDTH'(hit_line >> (32'(req_word) * CORE_DATA_WIDTH));

  always_comb begin
    victim        = '0;
    found_invalid = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found_invalid && !set_valid[WAY_W'(w)]) begin
        found_invalid = 1'b1;
        victim        = WAY_W'(w);
      end
    end
    if (!found_invalid) victim = plru_victim(plru_q[req_index]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    o_stall      = 1'b0;
    o_data_valid = 1'b0;
    o_mem_req    = 1'b0;
    hit_fire     = 1'b0;
    miss_start   = 1'b0;
    fill_fire    = 1'b0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          if (i_req) begin
            if (hit) begin
              o_data_valid = 1'b1;
              hit_fire     = 1'b1;
            end else begin
              o_stall    = 1'b1;
              miss_start = 1'b1;
              state_d    = REFILL;
            end
          end
        end
        REFILL: begin
          o_stall   = 1'b1;
          o_mem_req = 1'b1;
          if (i_mem_done) begin
            fill_fire = 1'b1;
            state_d   = FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          o_stall = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[INDEX_W'(s)] <= '0;
        plru_q[INDEX_W'(s)]  <= '0;
      end
      victim_q     <= '0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      if (hit_fire) begin
        if (hit_q != '1) hit_q <= hit_q + 32'd1;
        plru_q[req_index] <= plru_touch(plru_q[req_index], hit_way);
      end
      if (miss_start) begin
        if (miss_q != '1) miss_q <= miss_q + 32'd1;
        victim_q   <= victim;
        mem_addr_q <= {i_addr_from_core[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      if (fill_fire) begin
        valid_q[fill_index][victim_q] <= 1'b1;
        plru_q[fill_index]            <= plru_touch(plru_q[fill_index], victim_q);
      end
      // A flush seen mid-refill is held back until the FILL_WAIT -> IDLE
      // edge, so it also wipes the line that was just written.
      if (state_q == IDLE) begin
        if (i_flush) begin
          for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[INDEX_W'(s)] <= '0;
            plru_q[INDEX_W'(s)]  <= '0;
          end
        end
      end else if (state_q == FILL_WAIT && (flush_pend_q || i_flush)) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          valid_q[INDEX_W'(s)] <= '0;
          plru_q[INDEX_W'(s)]  <= '0;
        end
        flush_pend_q <= 1'b0;
      end else if (i_flush) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (fill_fire) begin
      data_mem[fill_index][victim_q] <= i_block_from_axi;
      tag_mem[fill_index][victim_q]  <= fill_tag;
    end
  end

  assign o_addr_from_control_to_axi = mem_addr_q;
  assign o_hit_count                = hit_q;
  assign o_miss_count               = miss_q;

endmodule

// File: tb/tb_riscv_core_icache_nway.sv
// Directed bench for riscv_core_icache_nway (2 ways, 128 sets, 32-byte lines).
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
module tb_riscv_core_icache_nway;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  addr;
  logic         req;
  logic         flush;
  logic         stall;
  logic         dv;
  logic [31:0]  data;
  logic [63:0]  axi_addr;
  logic         mem_req;
  logic         done;
  logic [255:0] block;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_core_icache_nway #(
    .ADDR_WIDTH(64),
    .CORE_DATA_WIDTH(32),
    .AXI_DATA_WIDTH(256),
    .SETS(128),
    .WAYS(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_addr_from_core(addr),
    .i_req(req),
    .i_flush(flush),
    .o_stall(stall),
    .o_data_valid(dv),
    .o_data_to_core(data),
    .o_addr_from_control_to_axi(axi_addr),
    .o_mem_req(mem_req),
    .i_mem_done(done),
    .i_block_from_axi(block),
    .o_hit_count(hit_cnt),
    .o_miss_count(miss_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  // Request a missing address, complete its refill, and stop in the cycle
  // where the held request hits word 0.
  task automatic miss_fill(input logic [63:0] a, input logic [31:0] base);
    addr = a;
    req  = 1'b1;
    #1 check("mf_stall", {63'd0, stall}, 64'd1);
    step();
    #1 check("mf_mem_req", {63'd0, mem_req}, 64'd1);
    check("mf_axi_addr", axi_addr, {a[63:5], 5'b0});
    block = mk_line(base);
    done  = 1'b1;
    step();
    done = 1'b0;
    #1 check("mf_wait_stall", {63'd0, stall}, 64'd1);
    check("mf_wait_valid", {63'd0, dv}, 64'd0);
    step();
    #1 check("mf_hit", {63'd0, dv}, 64'd1);
    check("mf_data", {32'd0, data}, {32'd0, base});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; flush = 1'b0; done = 1'b0; block = '0;
    @(negedge clk);
    #1 check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_valid", {63'd0, dv}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_hits", {32'd0, hit_cnt}, 64'd0);
    check("rst_misses", {32'd0, miss_cnt}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_axi", axi_addr, 64'd0);

    // First miss at 0x1000 with one extra cycle of memory latency.
    addr = 64'h1000; req = 1'b1;
    #1 check("m1_stall", {63'd0, stall}, 64'd1);
    check("m1_valid", {63'd0, dv}, 64'd0);
    step();
    #1 check("m1_mem_req", {63'd0, mem_req}, 64'd1);
    check("m1_axi", axi_addr, 64'h1000);
    check("m1_misses", {32'd0, miss_cnt}, 64'd1);
    step();
    #1 check("m1_hold_req", {63'd0, mem_req}, 64'd1);
    check("m1_hold_axi", axi_addr, 64'h1000);
    block = mk_line(32'hA000_0000); done = 1'b1;
    step();
    done = 1'b0;
    #1 check("m1_wait_stall", {63'd0, stall}, 64'd1);
    check("m1_req_drop", {63'd0, mem_req}, 64'd0);
    step();
    #1 check("m1_hit", {63'd0, dv}, 64'd1);
    check("m1_data", {32'd0, data}, 64'hA000_0000);
    check("m1_nostall", {63'd0, stall}, 64'd0);

    for (int k = 1; k < 8; k++) begin
      step();
      addr = 64'h1000 + 64'(4 * k);
      #1 check("seq_hit", {63'd0, dv}, 64'd1);
      check("seq_data", {32'd0, data}, {32'd0, 32'hA000_0000 + 32'(k)});
      check("seq_stall", {63'd0, stall}, 64'd0);
    end
    step();
    req = 1'b0;
    #1 check("seq_hits", {32'd0, hit_cnt}, 64'd8);
    check("idle_valid", {63'd0, dv}, 64'd0);
    check("idle_stall", {63'd0, stall}, 64'd0);
    step();
    #1 check("idle_hits", {32'd0, hit_cnt}, 64'd8);

    // PLRU: 0x1000 way0, 0x2000 way1, touch 0x1000, 0x3000 evicts 0x2000.
    miss_fill(64'h2000, 32'hB000_0000);
    step();
    addr = 64'h1000; req = 1'b1;
    #1 check("touch_hit", {63'd0, dv}, 64'd1);
    check("touch_data", {32'd0, data}, 64'hA000_0000);
    step();
    miss_fill(64'h3000, 32'hC000_0000);
    step();
    addr = 64'h1004;
    #1 check("keep_hit", {63'd0, dv}, 64'd1);
    check("keep_data", {32'd0, data}, 64'hA000_0001);
    step();
    miss_fill(64'h2000, 32'hB000_0000);
    step();
    req = 1'b0;
    #1 check("plru_misses", {32'd0, miss_cnt}, 64'd4);

    // Flush in IDLE: the same-cycle hit is still served, then 0x1000 misses.
    addr = 64'h1008; req = 1'b1; flush = 1'b1;
    #1 check("flush_hit", {63'd0, dv}, 64'd1);
    check("flush_data", {32'd0, data}, 64'hA000_0002);
    step();
    flush = 1'b0;
    miss_fill(64'h1000, 32'hA000_0000);
    step();

    // Flush during the refill of 0x4000: the refilled line is discarded.
    addr = 64'h4000; req = 1'b1;
    step();
    flush = 1'b1;
    #1 check("rf_mem_req", {63'd0, mem_req}, 64'd1);
    step();
    flush = 1'b0;
    block = mk_line(32'hD000_0000); done = 1'b1;
    step();
    done = 1'b0;
    step();
    #1 check("rf_remiss", {63'd0, stall}, 64'd1);
    check("rf_valid", {63'd0, dv}, 64'd0);
    miss_fill(64'h4000, 32'hD000_0000);
    step();
    req = 1'b0;
    #1 check("rf_misses", {32'd0, miss_cnt}, 64'd7);

    // Reset during a refill abandons it; a late i_mem_done is ignored.
    addr = 64'h5000; req = 1'b1;
    step();
    #1 check("rr_mem_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    #1 check("rr_rst_stall", {63'd0, stall}, 64'd0);
    step();
    rst = 1'b0; req = 1'b0;
    #1 check("rr_mem_req_off", {63'd0, mem_req}, 64'd0);
    block = mk_line(32'hE000_0000); done = 1'b1;
    step();
    done = 1'b0;
    #1 check("rr_misses", {32'd0, miss_cnt}, 64'd0);
    check("rr_hits", {32'd0, hit_cnt}, 64'd0);
    check("rr_axi", axi_addr, 64'd0);
    check("rr_mem_req_idle", {63'd0, mem_req}, 64'd0);
    miss_fill(64'h1000, 32'hA000_0000);
    step();
    miss_fill(64'h5000, 32'hE000_0000);
    step();
    req = 1'b0;
    #1 check("rr_miss_cnt", {32'd0, miss_cnt}, 64'd2);

    // Miss counter saturation.
    force dut.miss_q = 32'hFFFF_FFFF;
    step();
    release dut.miss_q;
    #1 check("sat_forced", {32'd0, miss_cnt}, 64'hFFFF_FFFF);
    miss_fill(64'h6000, 32'hF000_0000);
    step();
    req = 1'b0;
    #1 check("sat_misses", {32'd0, miss_cnt}, 64'hFFFF_FFFF);
    check("sat_hits", {32'd0, hit_cnt}, 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_core_icache_nway.md
Name: riscv_core_icache_nway

Overview:
- Parametrised N-way set-associative, read-only instruction cache between the core fetch stage and the AXI refill master.
- Generalises the direct-mapped icache with configurable sets and ways, tree pseudo-LRU replacement, a fetch-valid qualifier, a whole-cache flush for FENCE.I, and hit/miss performance counters.
- Hits return data combinationally in the request cycle; misses stall the core while one full line is fetched.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- CORE_DATA_WIDTH, 32, instruction word width returned to the core.
- AXI_DATA_WIDTH, 256, line size in bits; one refill beat.
- SETS, 128, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; power of 2, 1 to 8.
- Derived, not overridable:
  - OFFSET_W = log2(AXI_DATA_WIDTH/8)
  - INDEX_W = log2(SETS)
  - TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W
  - WORD_SEL_W = log2(AXI_DATA_WIDTH/CORE_DATA_WIDTH)

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_addr_from_core  in  ADDR_WIDTH  fetch address.
- i_req  in  1  fetch request valid.
- i_flush  in  1  invalidate all lines; single-cycle pulse.
- o_stall  out  1  core must hold i_addr_from_core and i_req.
- o_data_valid  out  1  o_data_to_core is valid this cycle.
- o_data_to_core  out  CORE_DATA_WIDTH  instruction word.
- o_addr_from_control_to_axi  out  ADDR_WIDTH  line-aligned refill address.
- o_mem_req  out  1  refill request; level-held until done.
- i_mem_done  in  1  refill complete; i_block_from_axi valid this cycle.
- i_block_from_axi  in  AXI_DATA_WIDTH  refill line; word 0 in bits [CORE_DATA_WIDTH-1:0].
- o_hit_count  out  32  saturating hit counter.
- o_miss_count  out  32  saturating miss counter.

Behaviour:
- Address split: tag = [ADDR_WIDTH-1 : INDEX_W+OFFSET_W]; index = next INDEX_W bits; word select = addr[OFFSET_W-1 : log2(CORE_DATA_WIDTH/8)]; low byte bits ignored.
- Storage: per set and way, one valid bit, one tag and one line. Valid bits and PLRU state are flops. Data and tag arrays are synchronous-write, asynchronous-read.
- FSM states:
  - IDLE
  - REFILL: o_mem_req=1.
  - FILL_WAIT: one cycle after the write, to allow the re-lookup.
- IDLE, i_req=1, tag match in any valid way:
  - o_data_valid=1, o_stall=0, same cycle.
  - Hit counter +1.
  - PLRU for the set updated to point away from the hit way.
- IDLE, i_req=1, no match:
  - o_stall=1 combinationally.
  - Miss counter +1 once per miss.
  - Victim way latched.
  - o_addr_from_control_to_axi = address with low OFFSET_W bits cleared, registered.
  - Go to REFILL.
- REFILL:
  - o_stall=1, o_mem_req=1, address held stable.
  - On i_mem_done: write line and tag into the victim way, set its valid bit, update PLRU, drop o_mem_req the next cycle, go to FILL_WAIT.
- FILL_WAIT:
  - o_stall=1, o_data_valid=0.
  - Next cycle go to IDLE, where the held request hits.
  - Minimum miss penalty = memory latency + 2 cycles.
- Victim selection: lowest-index invalid way first; else tree-PLRU victim. WAYS=1 always selects way 0.
- i_req=0 in IDLE: o_stall=0, o_data_valid=0, no counter or PLRU change.
- o_data_to_core is don't-care when o_data_valid=0. The bench checks it only when valid.
- Flush:
  - In IDLE, i_flush clears all valid bits and PLRU at the clock edge. A same-cycle i_req hit is still served from pre-flush state.
  - In REFILL or FILL_WAIT, the flush is recorded and applied on entry to IDLE, after the line write. The refilled line is therefore invalid, and the held request misses again.
- Counters: saturate at 0xFFFF_FFFF; cleared only by reset.
- i_mem_done outside REFILL is ignored.
- Reset, any state:
  - FSM to IDLE; all valid bits, PLRU, counters and pending flush cleared; o_mem_req=0 and o_addr_from_control_to_axi=0 next cycle.
  - While i_rst=1: o_stall=0, o_data_valid=0.
  - An in-flight refill is abandoned; its later i_mem_done is ignored.

Test Plan:
- Reset, then i_req with addr 0x1000 -> miss:
  - o_stall=1, o_mem_req=1, axi addr 0x1000.
  - i_mem_done with word k = 0xA000_000k -> two cycles later o_data_valid=1, data 0xA000_0000; miss_count=1.
- After the 0x1000 fill, fetch 0x1004..0x101C -> 7 consecutive single-cycle hits, data 0xA000_0001..0xA000_0007, o_stall=0; hit_count=8 (includes the retried 0x1000).
- WAYS=2, SETS=128: fill 0x1000 then 0x2000 (same index), touch 0x1000, fetch 0x3000 -> the 0x2000 way is evicted; 0x1000 still hits and 0x2000 misses.
- Flush in IDLE after fills -> next fetch of 0x1000 misses. Flush during REFILL of 0x4000 -> after i_mem_done, 0x4000 misses a second time.
- Reset asserted during REFILL -> o_mem_req=0 next cycle; a later i_mem_done produces no line write, and 0x1000 misses afterwards.
- Force miss_count to 0xFFFF_FFFF, then cause a miss -> counter stays 0xFFFF_FFFF.
